// File: rtl/input_fifo_dev_if.sv
// CPU-side register bus plus byte-stream input of the input FIFO device.
// The master drives addresses, strobes and the byte stream; the slave is the device.
interface input_fifo_dev_if;
    logic [31:0] address;
    logic [31:0] data;
    logic        MemRead;
    logic        MemWrite;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] data_out;
    logic        DeviceAddress;
    logic        DeviceInterrupt;

    modport master (
        output address, data, MemRead, MemWrite, in_valid, in_data,
        input  in_ready, data_out, DeviceAddress, DeviceInterrupt
    );

    modport slave (
        input  address, data, MemRead, MemWrite, in_valid, in_data,
        output in_ready, data_out, DeviceAddress, DeviceInterrupt
    );
endinterface

// File: rtl/input_fifo_dev.sv
// Memory-mapped byte input FIFO: an external producer pushes bytes, the CPU pops
// them through the DATA register and gets an interrupt when new bytes arrive.
module input_fifo_dev #(
    parameter int          DEPTH = 8,
    parameter logic [31:0] BASE  = 32'hffff0100
) (
    input logic              clk,
    input logic              reset,
    input_fifo_dev_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [31:0]   STATUS_ADDR  = BASE;
    localparam logic [31:0]   DATA_ADDR    = BASE + 32'd4;
    localparam logic [31:0]   CONTROL_ADDR = BASE + 32'd8;
    localparam logic [31:0]   ACK_ADDR     = BASE + 32'd12;
    localparam logic [AW-1:0] PTR_ONE      = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO     = {AW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_FULL     = CW'(DEPTH);

    logic [7:0]    buffer_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          ie_r;
    logic          pending_r;

    logic hit_status_s, hit_data_s, hit_control_s, hit_ack_s;
    logic full_s, nonempty_s;
    logic rd_s, wr_s;
    logic push_s, pop_s, flush_s, ctrl_wr_s, ack_s;
    logic [31:0] status_word_s;
    logic [31:0] rdata_s;
    logic        unused_data_s;

    // Only control bits 1:0 of store data carry meaning.
    assign unused_data_s = ^bus.data[31:2];

    // Address decode and per-cycle event qualification.
    always_comb begin
        hit_status_s  = (bus.address == STATUS_ADDR);
        hit_data_s    = (bus.address == DATA_ADDR);
        hit_control_s = (bus.address == CONTROL_ADDR);
        hit_ack_s     = (bus.address == ACK_ADDR);
        full_s        = (count_r == CNT_FULL);
        nonempty_s    = (count_r != CNT_ZERO);
        wr_s          = bus.MemWrite;
        // A simultaneous store takes priority: the load then has no side effects.
        rd_s          = bus.MemRead & ~bus.MemWrite;
        push_s        = bus.in_valid & ~full_s;
        pop_s         = rd_s & hit_data_s & nonempty_s;
        ctrl_wr_s     = wr_s & hit_control_s;
        flush_s       = ctrl_wr_s & bus.data[1];
        ack_s         = wr_s & hit_ack_s;
    end

    // Pointer, occupancy and control/status state.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r    <= PTR_ZERO;
            tail_r    <= PTR_ZERO;
            count_r   <= CNT_ZERO;
            ie_r      <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                ie_r <= bus.data[0];
            end
            if (flush_s) begin
                head_r    <= PTR_ZERO;
                tail_r    <= PTR_ZERO;
                count_r   <= CNT_ZERO;
                pending_r <= 1'b0;
            end else begin
                if (push_s) begin
                    tail_r <= tail_r + PTR_ONE;
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_ONE;
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
                // A new byte re-arms the request even if it is acknowledged this cycle.
                if (push_s) begin
                    pending_r <= 1'b1;
                end else if (ack_s) begin
                    pending_r <= 1'b0;
                end
            end
        end
    end

    // Byte storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            buffer_r[tail_r] <= bus.in_data;
        end
    end

    // CPU load data mux.
    always_comb begin
        status_word_s = {16'h0000, 8'(count_r), 4'h0, pending_r, ie_r, full_s, nonempty_s};
        rdata_s       = 32'h0000_0000;
        if (bus.MemRead) begin
            if (hit_status_s) begin
                rdata_s = status_word_s;
            end else if (hit_data_s) begin
                rdata_s = nonempty_s ? {24'h000000, buffer_r[head_r]} : 32'h0000_0000;
            end else if (hit_control_s) begin
                rdata_s = {31'h0000_0000, ie_r};
            end else begin
                rdata_s = 32'h0000_0000;
            end
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign bus.data_out        = rdata_s;
    assign bus.DeviceAddress   = hit_status_s | hit_data_s | hit_control_s | hit_ack_s;
    assign bus.in_ready        = ~full_s;
    assign bus.DeviceInterrupt = ie_r & pending_r;
endmodule

// File: tb/tb_input_fifo_dev.sv
// Self-checking bench for input_fifo_dev against a queue-based reference model.
module tb_input_fifo_dev;
    localparam int          DEPTH  = 8;
    localparam logic [31:0] BASE   = 32'hffff0100;
    localparam logic [31:0] A_STAT = BASE;
    localparam logic [31:0] A_DATA = BASE + 32'd4;
    localparam logic [31:0] A_CTRL = BASE + 32'd8;
    localparam logic [31:0] A_ACK  = BASE + 32'd12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    input_fifo_dev_if bus();

    input_fifo_dev #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] mq[$];
    bit m_ie = 1'b0;
    bit m_pend = 1'b0;

    function automatic logic [31:0] exp_rdata();
        int n;
        n = mq.size();
        if (!bus.MemRead) return 32'h0;
        if (bus.address == A_STAT)
            return 32'(n * 256 + (m_pend ? 8 : 0) + (m_ie ? 4 : 0) + (n == DEPTH ? 2 : 0) + (n > 0 ? 1 : 0));
        if (bus.address == A_DATA) return (n > 0) ? 32'(mq[0]) : 32'h0;
        if (bus.address == A_CTRL) return m_ie ? 32'h1 : 32'h0;
        return 32'h0;
    endfunction

    function automatic logic exp_devaddr();
        return (bus.address == A_STAT) || (bus.address == A_DATA) ||
               (bus.address == A_CTRL) || (bus.address == A_ACK);
    endfunction

    task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic rd,
                         input logic wr, input logic iv, input logic [7:0] id,
                         input logic rst = 1'b0);
        @(negedge clk);
        bus.address  = a;
        bus.data     = d;
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.in_valid = iv;
        bus.in_data  = id;
        reset        = rst;
        #1;
    endtask

    task automatic clock_edge();
        bit push, pop, flush, ack, cw;
        push  = bus.in_valid && (mq.size() < DEPTH);
        pop   = bus.MemRead && !bus.MemWrite && bus.address == A_DATA && mq.size() > 0;
        cw    = bus.MemWrite && bus.address == A_CTRL;
        flush = cw && bus.data[1];
        ack   = bus.MemWrite && bus.address == A_ACK;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_ie = 1'b0;
            m_pend = 1'b0;
        end else begin
            if (cw) m_ie = bus.data[0];
            if (flush) begin
                mq.delete();
                m_pend = 1'b0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    mq.push_back(bus.in_data);
                    m_pend = 1'b1;
                end else if (ack) begin
                    m_pend = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        apply(A_CTRL, 32'h3, 1'b0, 1'b1, 1'b1, 8'hee, 1'b1);
        clock_edge();
        reset = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        apply(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, b);
        clock_edge();
    endtask

    task automatic test_reset();
        do_reset();
        apply(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.data_out !== 32'h0) begin bad++; $display("FAIL reset_status got=%h want=%h", bus.data_out, 32'h0); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.DeviceInterrupt !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", bus.DeviceInterrupt); end
        clock_edge();
    endtask

    task automatic test_basic();
        do_reset();
        push_byte(8'h41);
        push_byte(8'h42);
        apply(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.data_out !== 32'h0000_0209) begin bad++; $display("FAIL basic_status got=%h want=%h", bus.data_out, 32'h209); end
        total++; if (bus.DeviceInterrupt !== 1'b0) begin bad++; $display("FAIL basic_irq got=%b want=0", bus.DeviceInterrupt); end
        clock_edge();
        apply(A_DATA, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.data_out !== 32'h41) begin bad++; $display("FAIL basic_data0 got=%h want=%h", bus.data_out, 32'h41); end
        clock_edge();
        apply(A_DATA, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.data_out !== 32'h42) begin bad++; $display("FAIL basic_data1 got=%h want=%h", bus.data_out, 32'h42); end
        clock_edge();
        apply(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.data_out !== 32'h8) begin bad++; $display("FAIL basic_status_empty got=%h want=%h", bus.data_out, 32'h8); end
        clock_edge();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
            total++; if (bus.in_ready !== (i < 8)) begin bad++; $display("FAIL full_ready[%0d] got=%b want=%b", i, bus.in_ready, (i < 8)); end
            clock_edge();
        end
        apply(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.data_out !== 32'h0000_080b) begin bad++; $display("FAIL full_status got=%h want=%h", bus.data_out, 32'h80b); end
        clock_edge();
        apply(A_DATA, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.data_out !== 32'h10) begin bad++; $display("FAIL full_pop got=%h want=%h", bus.data_out, 32'h10); end
        clock_edge();
        apply(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop got=%b want=1", bus.in_ready); end
        clock_edge();
        for (int i = 1; i < 9; i++) begin
            apply(A_DATA, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
            total++; if (bus.data_out !== exp_rdata()) begin bad++; $display("FAIL full_drain[%0d] got=%h want=%h", i, bus.data_out, exp_rdata()); end
            clock_edge();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        do_reset();
        push_byte(8'ha0);
        push_byte(8'ha1);
        push_byte(8'ha2);
        apply(A_DATA, 32'h0, 1'b1, 1'b0, 1'b1, 8'ha3);
        total++; if (bus.data_out !== 32'ha0) begin bad++; $display("FAIL b2b_first got=%h want=%h", bus.data_out, 32'ha0); end
        clock_edge();
        apply(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.data_out !== 32'h0000_0309) begin bad++; $display("FAIL b2b_status got=%h want=%h", bus.data_out, 32'h309); end
        clock_edge();
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            apply(A_DATA, 32'h0, 1'b1, 1'b0, 1'b1, b);
            total++; if (bus.data_out !== exp_rdata()) begin bad++; $display("FAIL b2b_pair[%0d] got=%h want=%h", i, bus.data_out, exp_rdata()); end
            clock_edge();
        end
        apply(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.data_out !== 32'h0000_0309) begin bad++; $display("FAIL b2b_status_end got=%h want=%h", bus.data_out, 32'h309); end
        clock_edge();
    endtask

    task automatic test_irq();
        do_reset();
        apply(A_CTRL, 32'h1, 1'b0, 1'b1, 1'b0, 8'h00);
        clock_edge();
        push_byte(8'h55);
        apply(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (bus.DeviceInterrupt !== 1'b1) begin bad++; $display("FAIL irq_set got=%b want=1", bus.DeviceInterrupt); end
        clock_edge();
        apply(A_ACK, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
        clock_edge();
        apply(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (bus.DeviceInterrupt !== 1'b0) begin bad++; $display("FAIL irq_ack got=%b want=0", bus.DeviceInterrupt); end
        clock_edge();
        apply(A_ACK, 32'h0, 1'b0, 1'b1, 1'b1, 8'h66);
        clock_edge();
        apply(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (bus.DeviceInterrupt !== 1'b1) begin bad++; $display("FAIL irq_ack_vs_push got=%b want=1", bus.DeviceInterrupt); end
        clock_edge();
        apply(A_CTRL, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
        clock_edge();
        apply(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.DeviceInterrupt !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b want=0", bus.DeviceInterrupt); end
        total++; if (bus.data_out !== 32'h0000_0209) begin bad++; $display("FAIL irq_masked_status got=%h want=%h", bus.data_out, 32'h209); end
        clock_edge();
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'(8'h30 + i));
        apply(A_CTRL, 32'h3, 1'b0, 1'b1, 1'b1, 8'h99);
        clock_edge();
        apply(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.data_out !== 32'h4) begin bad++; $display("FAIL flush_status got=%h want=%h", bus.data_out, 32'h4); end
        total++; if (bus.DeviceInterrupt !== 1'b0) begin bad++; $display("FAIL flush_irq got=%b want=0", bus.DeviceInterrupt); end
        clock_edge();
        apply(A_DATA, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.data_out !== 32'h0) begin bad++; $display("FAIL flush_data got=%h want=%h", bus.data_out, 32'h0); end
        clock_edge();
        apply(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.data_out !== 32'h4) begin bad++; $display("FAIL flush_empty_read got=%h want=%h", bus.data_out, 32'h4); end
        clock_edge();
    endtask

    task automatic test_decode();
        logic [31:0] addrs [6];
        addrs = '{32'hffff0110, 32'h10010000, A_STAT, A_DATA, A_CTRL, A_ACK};
        do_reset();
        push_byte(8'h11);
        push_byte(8'h22);
        for (int i = 0; i < 6; i++) begin
            apply(addrs[i], 32'h0, (i < 2), 1'b0, 1'b0, 8'h00);
            total++; if (bus.DeviceAddress !== (i >= 2)) begin bad++; $display("FAIL decode_hit[%0d] got=%b want=%b", i, bus.DeviceAddress, (i >= 2)); end
            if (i < 2) begin
                total++; if (bus.data_out !== 32'h0) begin bad++; $display("FAIL decode_data[%0d] got=%h want=%h", i, bus.data_out, 32'h0); end
            end
            clock_edge();
        end
        apply(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (bus.data_out !== 32'h0000_0209) begin bad++; $display("FAIL decode_unchanged got=%h want=%h", bus.data_out, 32'h209); end
        clock_edge();
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic rd, wr;
        int sel;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    a = A_STAT;
                2, 3, 4: a = A_DATA;
                5:       a = A_CTRL;
                6:       a = A_ACK;
                7:       a = BASE + 32'd16;
                default: a = $urandom;
            endcase
            d  = $urandom;
            if ($urandom_range(0, 7) != 0) d[1] = 1'b0;
            rd = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 3) == 0);
            apply(a, d, rd, wr, ($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 149) == 0));
            total++; if (bus.data_out !== exp_rdata()) begin bad++; $display("FAIL rnd_data[%0d] got=%h want=%h", i, bus.data_out, exp_rdata()); end
            total++; if (bus.DeviceAddress !== exp_devaddr()) begin bad++; $display("FAIL rnd_devaddr[%0d] got=%b want=%b", i, bus.DeviceAddress, exp_devaddr()); end
            total++; if (bus.in_ready !== (mq.size() < DEPTH)) begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", i, bus.in_ready, (mq.size() < DEPTH)); end
            total++; if (bus.DeviceInterrupt !== (m_ie && m_pend)) begin bad++; $display("FAIL rnd_irq[%0d] got=%b want=%b", i, bus.DeviceInterrupt, (m_ie && m_pend)); end
            clock_edge();
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.address = 32'h0;
        bus.data = 32'h0;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_irq();
        test_flush();
        test_decode();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
